md_iter_unit: RTL and testbench
===============================

// Module: md_iter_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage; successor to the
//  single-cycle MD processor. Owns the HI/LO registers and runs MULT/DIV over
//  WIDTH/BITS_PER_CYCLE iterations. While an operation runs, busy stalls the
//  pipeline. An EX flush cancels an in-flight operation without touching HI/LO.
// PARAMETERS
//  WIDTH           32  operand / HI / LO width in bits
//  BITS_PER_CYCLE  1   quotient/multiplier bits retired per iteration (1,2,4; must divide WIDTH)
// PORTS
//  clk      in   1      clock; all state changes on posedge
//  rst      in   1      reset, synchronous, active-high
//  start    in   1      issue op this cycle (from EX control)
//  flush    in   1      EX_FLUSH: cancel in-flight op, block start this cycle
//  op       in   3      000 NOP, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO, others NOP
//  is_sign  in   1      1 = signed (two's complement) MULT/DIV
//  a        in   WIDTH  operand A (forwarded rs)
//  b        in   WIDTH  operand B (forwarded rt)
//  busy     out  1      op in flight; EX must hold and re-present nothing new
//  done     out  1      1-cycle pulse, first cycle new MULT/DIV HI/LO are visible
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (sync): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//  N = WIDTH/BITS_PER_CYCLE. States: IDLE, RUN, FIX. busy = (state != IDLE).
//  IDLE: start & !flush & op=MULT/DIV -> latch |a|,|b| (magnitudes if is_sign, else raw)
//    and result signs, counter=0, -> RUN. Operands changing after this edge are ignored.
//  IDLE: start & !flush & op=MTHI -> hi<=a; op=MTLO -> lo<=a; stay IDLE, busy stays 0.
//  RUN: each edge retires BITS_PER_CYCLE bits (shift-add mult / restoring div on
//    magnitudes), counter++. After the N-th RUN edge -> FIX.
//  FIX: sign-correct, write hi/lo, -> IDLE; done=1 for the next cycle only.
//  Latency: start edge k; busy high cycles k+1..k+N+1; hi/lo/done valid at cycle k+N+2.
//  MULT: {hi,lo} = a*b, 2*WIDTH-bit product; signed: negate magnitude product when signs differ.
//  DIV: lo = quotient, hi = remainder. Signed: quotient truncates toward zero;
//    remainder takes the sign of the dividend.
//  DIV by zero (either signedness): hi = a, lo = all ones. Completes in the normal N+1 cycles.
//  Signed MIN / -1: lo = MIN, hi = 0 (no trap).
//  start while busy: ignored entirely, including MTHI/MTLO. Pipeline must stall on busy.
//  flush in RUN/FIX: -> IDLE on that edge, hi/lo unchanged, no done pulse.
//  flush & start in IDLE: start ignored.
//  rst mid-op: overrides everything, reset values above.
// TESTING (WIDTH=32, BITS_PER_CYCLE=1, N=32)
//  1 unsigned MULT 0xFFFFFFFF*2 -> busy 33 cycles, done pulse; hi=0x1, lo=0xFFFFFFFE
//  2 signed DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1
//  3 DIV 5/0 (signed and unsigned) -> hi=0x5, lo=0xFFFFFFFF; signed 0x80000000/-1 -> lo=0x80000000, hi=0
//  4 MTHI 0x1234, then MULT, flush on 10th busy cycle -> busy=0 next cycle, no done, hi=0x1234
//  5 MTLO 0xAA while busy -> ignored, lo holds the MULT result; MTLO in IDLE -> lo=0xAA next cycle, busy=0
//  6 rst asserted mid-DIV -> next cycle hi=lo=0, busy=0, done=0; rerun with BITS_PER_CYCLE=4 -> busy 9 cycles

Source files
------------

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide unit that owns HI/LO and retires BITS_PER_CYCLE bits per clock.
// MULT uses a shift-add datapath and DIV a restoring datapath, both on operand magnitudes.
module md_iter_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic             is_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, hi_q, lo_q;
    logic                 isDiv_q, negLo_q, negHi_q, divZero_q, done_q;
    logic [WIDTH-1:0]     magA, magB;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quoFix, remFix;

    assign magA = (is_sign && a[WIDTH-1]) ? -a : a;
    assign magB = (is_sign && b[WIDTH-1]) ? -b : b;

    // acc_q holds {partial product, remaining multiplier} for MULT and {remainder, dividend/quotient} for DIV
    always_comb begin
        logic [WIDTH+K-1:0] partial;
        logic [WIDTH+K-1:0] mulTerm;
        logic [WIDTH:0]     r;
        logic [WIDTH-1:0]   rem;
        logic [WIDTH-1:0]   quo;
        acc_d   = acc_q;
        partial = '0;
        mulTerm = '0;
        r       = '0;
        rem     = acc_q[2*WIDTH-1:WIDTH];
        quo     = acc_q[WIDTH-1:0];
        if (isDiv_q) begin
            for (int i = 0; i < K; i++) begin
                r   = {rem, quo[WIDTH-1]};
                quo = {quo[WIDTH-2:0], 1'b0};
                if (r >= {1'b0, opnd_q}) begin
                    r      = r - {1'b0, opnd_q};
                    quo[0] = 1'b1;
                end
                rem = r[WIDTH-1:0];
            end
            acc_d = {rem, quo};
        end else begin
            mulTerm = {{K{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[K-1:0]};
            partial = {{K{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + mulTerm;
            acc_d   = {partial, acc_q[WIDTH-1:K]};
        end
    end

    always_comb begin
        prodFix = negLo_q ? -acc_q : acc_q;
        quoFix  = divZero_q ? {WIDTH{1'b1}}
                            : (negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        remFix  = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            isDiv_q   <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_DIV: begin
                                acc_q     <= {{WIDTH{1'b0}}, magA};
                                opnd_q    <= magB;
                                cnt_q     <= '0;
                                isDiv_q   <= (op == OP_DIV);
                                // a zero divisor keeps the all-ones quotient un-negated
                                negLo_q   <= is_sign && (a[WIDTH-1] ^ b[WIDTH-1])
                                             && !((op == OP_DIV) && (b == '0));
                                negHi_q   <= is_sign && a[WIDTH-1];
                                divZero_q <= (b == '0);
                                state_q   <= RUN;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(N - 1)) state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (isDiv_q) begin
                            hi_q <= remFix;
                            lo_q <= quoFix;
                        end else begin
                            {hi_q, lo_q} <= prodFix;
                        end
                        done_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Bench for md_iter_unit: two instances (1 and 4 bits per cycle) checked against
// a plain-arithmetic HI/LO model, with directed corner cases and random operations.
module tb_md_iter_unit;

    localparam logic [2:0] MULT = 3'b001;
    localparam logic [2:0] DIV  = 3'b010;
    localparam logic [2:0] MTHI = 3'b011;
    localparam logic [2:0] MTLO = 3'b100;

    logic        clk = 1'b0;
    logic        rst, flush, isSign;
    logic [1:0]  start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [1:0]  busyV, doneV;
    logic [31:0] hiV [2];
    logic [31:0] loV [2];
    logic [31:0] hiM [2];
    logic [31:0] loM [2];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    md_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[0]), .flush(flush), .op(op), .is_sign(isSign),
        .a(a), .b(b), .busy(busyV[0]), .done(doneV[0]), .hi(hiV[0]), .lo(loV[0]));

    md_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start[1]), .flush(flush), .op(op), .is_sign(isSign),
        .a(a), .b(b), .busy(busyV[1]), .done(doneV[1]), .hi(hiV[1]), .lo(loV[1]));

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // HI/LO after an operation, computed with ordinary 64-bit and integer arithmetic
    task automatic refModel(input logic [2:0] o, input logic s, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] inHi, input logic [31:0] inLo,
                            output logic [31:0] outHi, output logic [31:0] outLo);
        logic [63:0] p;
        int sx, sy;
        outHi = inHi;
        outLo = inLo;
        sx = x;
        sy = y;
        case (o)
            MULT: begin
                if (s) p = 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
                else   p = {32'b0, x} * {32'b0, y};
                {outHi, outLo} = p;
            end
            DIV: begin
                if (y == 0) begin
                    outHi = x;
                    outLo = 32'hFFFF_FFFF;
                end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    outHi = 32'h0;
                    outLo = 32'h8000_0000;
                end else if (s) begin
                    outLo = 32'(sx / sy);
                    outHi = 32'(sx % sy);
                end else begin
                    outLo = x / y;
                    outHi = x % y;
                end
            end
            MTHI: outHi = x;
            MTLO: outLo = x;
            default: ;
        endcase
    endtask

    // midAct: 0 none, 1 flush, 2 MTLO 0xAA while busy, 3 reset -- applied on busy sample midAt
    task automatic applyStimulus(input int d, input logic [2:0] o, input logic s,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input int midAt, input int midAct);
        int n, busyCnt, doneCnt, doneAt;
        logic [31:0] eh, el;
        bit cut;
        n = (d == 0) ? 32 : 8;
        refModel(o, s, x, y, hiM[d], loM[d], eh, el);
        @(negedge clk);
        op = o; isSign = s; a = x; b = y; start[d] = 1'b1;
        @(negedge clk);
        start = '0; op = 3'($urandom_range(0, 7)); isSign = 1'($urandom); a = $urandom; b = $urandom;
        if (o != MULT && o != DIV) begin
            checkOutput("idle_busy", {63'b0, busyV[d]}, 64'd0);
            checkOutput("reg_hi", {32'b0, hiV[d]}, {32'b0, eh});
            checkOutput("reg_lo", {32'b0, loV[d]}, {32'b0, el});
            hiM[d] = eh;
            loM[d] = el;
            return;
        end
        busyCnt = 0; doneCnt = 0; doneAt = 0; cut = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            if (busyV[d]) busyCnt++;
            if (doneV[d]) begin
                doneCnt++;
                if (doneAt == 0) doneAt = c;
            end
            if (c == midAt) begin
                case (midAct)
                    1: flush = 1'b1;
                    2: begin start[d] = 1'b1; op = MTLO; a = 32'hAA; end
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk);
            flush = 1'b0; start = '0; rst = 1'b0;
            if (c == midAt && (midAct == 1 || midAct == 3)) begin
                cut = 1'b1;
                break;
            end
        end
        if (cut) begin
            if (midAct == 3) begin
                hiM[0] = '0; loM[0] = '0; hiM[1] = '0; loM[1] = '0;
            end
            checkOutput("cut_busy", {63'b0, busyV[d]}, 64'd0);
            checkOutput("cut_done", {63'b0, doneV[d]}, 64'd0);
            checkOutput("cut_hi", {32'b0, hiV[d]}, {32'b0, hiM[d]});
            checkOutput("cut_lo", {32'b0, loV[d]}, {32'b0, loM[d]});
            @(negedge clk);
            checkOutput("cut_nodone", {63'b0, doneV[d]}, 64'd0);
            return;
        end
        checkOutput("busy_cycles", 64'(busyCnt), 64'(n + 1));
        checkOutput("done_cycle", 64'(doneAt), 64'(n + 2));
        checkOutput("done_pulses", 64'(doneCnt), 64'd1);
        checkOutput("md_hi", {32'b0, hiV[d]}, {32'b0, eh});
        checkOutput("md_lo", {32'b0, loV[d]}, {32'b0, el});
        hiM[d] = eh;
        loM[d] = el;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    // Directed corner cases first, then a random mix on both instances
    initial begin
        logic [2:0] ro;
        rst = 1'b1; flush = 1'b0; start = '0; op = '0; isSign = 1'b0; a = '0; b = '0;
        hiM[0] = '0; loM[0] = '0; hiM[1] = '0; loM[1] = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_busy", {63'b0, busyV[d]}, 64'd0);
            checkOutput("rst_done", {63'b0, doneV[d]}, 64'd0);
            checkOutput("rst_hi", {32'b0, hiV[d]}, 64'd0);
            checkOutput("rst_lo", {32'b0, loV[d]}, 64'd0);
        end
        rst = 1'b0;

        applyStimulus(0, MULT, 1'b0, 32'hFFFF_FFFF, 32'h2, 0, 0);
        checkOutput("vec_umult_hi", {32'b0, hiV[0]}, 64'h1);
        checkOutput("vec_umult_lo", {32'b0, loV[0]}, 64'hFFFF_FFFE);
        applyStimulus(0, DIV, 1'b1, 32'hFFFF_FFF9, 32'h2, 0, 0);
        checkOutput("vec_sdiv_lo", {32'b0, loV[0]}, 64'hFFFF_FFFD);
        applyStimulus(0, MULT, 1'b1, 32'hFFFF_FFFD, 32'h5, 0, 0);
        checkOutput("vec_smult_lo", {32'b0, loV[0]}, 64'hFFFF_FFF1);
        applyStimulus(0, DIV, 1'b1, 32'h5, 32'h0, 0, 0);
        applyStimulus(0, DIV, 1'b0, 32'h5, 32'h0, 0, 0);
        checkOutput("vec_div0_hi", {32'b0, hiV[0]}, 64'h5);
        applyStimulus(0, DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        checkOutput("vec_minneg1_lo", {32'b0, loV[0]}, 64'h8000_0000);

        applyStimulus(0, MTHI, 1'b0, 32'h1234, 32'h0, 0, 0);
        applyStimulus(0, MULT, 1'b0, 32'h1357_9BDF, 32'h0246_8ACE, 10, 1);
        checkOutput("vec_flush_hi", {32'b0, hiV[0]}, 64'h1234);
        applyStimulus(0, MULT, 1'b0, 32'h0001_0001, 32'h0000_0300, 5, 2);
        applyStimulus(0, MTLO, 1'b0, 32'hAA, 32'h0, 0, 0);

        @(negedge clk);
        flush = 1'b1; start[0] = 1'b1; op = MTHI; a = 32'hDEAD;
        @(negedge clk);
        flush = 1'b0; start = '0;
        checkOutput("flush_start_hi", {32'b0, hiV[0]}, {32'b0, hiM[0]});

        applyStimulus(0, DIV, 1'b0, 32'h0012_3456, 32'h7, 7, 3);
        applyStimulus(1, DIV, 1'b1, 32'hFFFF_FF00, 32'h13, 0, 0);
        applyStimulus(1, MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    ro = MULT;
                2, 3:    ro = DIV;
                4:       ro = ($urandom_range(0, 1) == 0) ? MTHI : MTLO;
                default: ro = 3'b111;
            endcase
            applyStimulus(i % 2, ro, 1'($urandom), pickOperand(), pickOperand(), 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
